// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios PIO-style slaves: register map offsets and bus width.
package nios_pio_pkg;

    localparam int BUS_DATA_W = 32;

    localparam logic [1:0] ADDR_DATA       = 2'd0;
    localparam logic [1:0] ADDR_BLINK_MASK = 2'd1;
    localparam logic [1:0] ADDR_SET        = 2'd2;
    localparam logic [1:0] ADDR_CLEAR      = 2'd3;

endpackage

// File: rtl/nios_blink_prescaler.sv
// Free-running blink prescaler; phase toggles each time the counter wraps to zero,
// giving a full blink period of 2^(BLINK_DIV_W+1) clocks.
module nios_blink_prescaler #(
    parameter int BLINK_DIV_W = 24
) (
    input  logic clk,
    input  logic reset,
    output logic phase
);

    logic [BLINK_DIV_W-1:0] cnt_r;
    logic                   phase_r;

    // Prescaler counter and phase flip-flop; phase flips on the all-ones -> 0 wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_r + BLINK_DIV_W'(1);
            phase_r <= phase_r ^ (&cnt_r);
        end
    end

    assign phase = phase_r;

endmodule

// File: rtl/nios_leds_out.sv
// Avalon-MM LED output port with DATA/SET/CLEAR registers and an optional blink mask.
// Blink logic is compiled in only when NIOS_LEDS_BLINK_EN is defined.
module nios_leds_out
    import nios_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               BLINK_DIV_W = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [BUS_DATA_W-1:0] writedata,
    output logic [BUS_DATA_W-1:0] readdata,
    output logic [WIDTH-1:0]      out_port
);

    logic                  wr_en_s;
    logic [WIDTH-1:0]      wr_val_s;
    logic [WIDTH-1:0]      data_r;
    logic [WIDTH-1:0]      data_nxt_s;
    logic [WIDTH-1:0]      mask_s;
    logic                  phase_s;
    logic [BUS_DATA_W-1:0] rd_nxt_s;
    logic                  unused_wd_s;

    assign wr_en_s     = chipselect & ~write_n;
    assign wr_val_s    = writedata[WIDTH-1:0];
    assign unused_wd_s = ^writedata;

    // Next DATA value from DATA/SET/CLEAR writes
    always_comb begin
        data_nxt_s = data_r;
        if (wr_en_s) begin
            case (address)
                ADDR_DATA:  data_nxt_s = wr_val_s;
                ADDR_SET:   data_nxt_s = data_r | wr_val_s;
                ADDR_CLEAR: data_nxt_s = data_r & ~wr_val_s;
                default:    data_nxt_s = data_r;
            endcase
        end else begin
            data_nxt_s = data_r;
        end
    end

    // DATA register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r <= RESET_VALUE;
        end else begin
            data_r <= data_nxt_s;
        end
    end

`ifdef NIOS_LEDS_BLINK_EN
    logic [WIDTH-1:0] mask_r;

    // BLINK_MASK register; writing it leaves the prescaler phase untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r <= '0;
        end else if (wr_en_s && (address == ADDR_BLINK_MASK)) begin
            mask_r <= wr_val_s;
        end else begin
            mask_r <= mask_r;
        end
    end

    nios_blink_prescaler #(
        .BLINK_DIV_W (BLINK_DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .phase (phase_s)
    );

    assign mask_s = mask_r;
`else
    localparam int unused_div_w = BLINK_DIV_W;

    assign mask_s  = '0;
    assign phase_s = 1'b0;
`endif

    // Read mux, sampled every clock regardless of chipselect
    always_comb begin
        rd_nxt_s = '0;
        case (address)
            ADDR_DATA:       rd_nxt_s[WIDTH-1:0] = data_r;
            ADDR_BLINK_MASK: rd_nxt_s[WIDTH-1:0] = mask_s;
            default:         rd_nxt_s = '0;
        endcase
    end

    // Registered read data (one-cycle read latency)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_nxt_s;
        end
    end

    // LEDs are a pure function of flops, so bus inputs never reach the pins combinationally
    assign out_port = data_r ^ (mask_s & {WIDTH{phase_s}});

endmodule

// File: tb/tb_nios_leds_out.sv
// Self-checking bench for nios_leds_out: directed scenarios plus randomized bus traffic
// compared every cycle against a tick-counting behavioural model.
module tb_nios_leds_out;

    localparam int         W     = 8;
    localparam int         DIV_W = 3;
    localparam logic [7:0] RV    = 8'h00;
`ifdef NIOS_LEDS_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // model state
    logic [7:0]  m_data;
    logic [7:0]  m_mask;
    logic [31:0] m_rd;
    int          m_ticks;

    nios_leds_out #(
        .WIDTH       (W),
        .RESET_VALUE (RV),
        .BLINK_DIV_W (DIV_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase is simply bit DIV_W of the number of edges since reset
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data  <= RV;
            m_mask  <= 8'h00;
            m_rd    <= 32'd0;
            m_ticks <= 0;
        end else begin
            case (address)
                2'd0:    m_rd <= {24'd0, m_data};
                2'd1:    m_rd <= BLINK_EN ? {24'd0, m_mask} : 32'd0;
                default: m_rd <= 32'd0;
            endcase
            if (chipselect && !write_n) begin
                case (address)
                    2'd0:    m_data <= writedata[7:0];
                    2'd1:    m_mask <= BLINK_EN ? writedata[7:0] : m_mask;
                    2'd2:    m_data <= m_data | writedata[7:0];
                    default: m_data <= m_data & ~writedata[7:0];
                endcase
            end
            m_ticks <= m_ticks + 1;
        end
    end

    function automatic logic [7:0] exp_out();
        bit ph;
        ph = BLINK_EN && (((m_ticks >> DIV_W) & 1) == 1);
        return m_data ^ (ph ? m_mask : 8'h00);
    endfunction

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_out_port", {24'd0, out_port}, {24'd0, exp_out()});
            check("model_readdata", readdata, m_rd);
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = $urandom;
    endtask

    // Assert reset between edges, check outputs immediately, release on the next falling edge
    task automatic async_reset(input bit do_check);
        #2 reset = 1'b1;
        #1;
        if (do_check) begin
            check("async_rst_out", {24'd0, out_port}, {24'd0, RV});
            check("async_rst_rd", readdata, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("rst_out", {24'd0, out_port}, 32'h0000_0000);
        check("rst_rd", readdata, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_out", {24'd0, out_port}, 32'h0000_0000);

        bus_write(2'd0, 32'h0000_00A5);
        check("data_wr_out", {24'd0, out_port}, 32'h0000_00A5);
        address = 2'd0;
        @(negedge clk);
        check("data_rd", readdata, 32'h0000_00A5);

        bus_write(2'd0, 32'h0000_000F);
        bus_write(2'd2, 32'h0000_00F0);
        check("set_out", {24'd0, out_port}, 32'h0000_00FF);
        bus_write(2'd3, 32'h0000_003C);
        check("clear_out", {24'd0, out_port}, 32'h0000_00C3);
        bus_write(2'd0, 32'hFFFF_FF00);
        check("upper_ignored_out", {24'd0, out_port}, 32'h0000_0000);

        // chipselect low must not write
        address = 2'd0; writedata = 32'h0000_0077; chipselect = 1'b0; write_n = 1'b0;
        @(negedge clk);
        write_n = 1'b1;
        check("no_cs_out", {24'd0, out_port}, 32'h0000_0000);

`ifdef NIOS_LEDS_BLINK_EN
        async_reset(1'b1);
        bus_write(2'd0, 32'h0000_0001);
        bus_write(2'd1, 32'h0000_0080);
        address = 2'd1;
        for (int n = 3; n <= 12; n++) begin
            @(negedge clk);
            check("blink_out", {24'd0, out_port}, ((n / 8) % 2 == 1) ? 32'h81 : 32'h01);
            if (n == 3) check("mask_rd", readdata, 32'h0000_0080);
        end
        async_reset(1'b1);
        bus_write(2'd0, 32'h0000_0001);
        bus_write(2'd1, 32'h0000_0080);
        for (int n = 3; n <= 7; n++) begin
            @(negedge clk);
            check("restart_out", {24'd0, out_port}, 32'h0000_0001);
        end
        bus_write(2'd2, 32'h0000_0002);
        check("collision_out", {24'd0, out_port}, 32'h0000_0083);
        @(negedge clk);
        check("collision_hold", {24'd0, out_port}, 32'h0000_0083);
`else
        bus_write(2'd1, 32'h0000_00FF);
        address = 2'd1;
        @(negedge clk);
        check("nomask_rd", readdata, 32'd0);
        check("nomask_out", {24'd0, out_port}, 32'h0000_0000);
        bus_write(2'd0, 32'h0000_005A);
        repeat (20) @(negedge clk);
        check("nomask_steady", {24'd0, out_port}, 32'h0000_005A);
`endif

        for (int i = 0; i < 1500; i++) begin
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'($urandom_range(0, 1));
            writedata  = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                async_reset(1'b0);
            end else begin
                @(negedge clk);
            end
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nios_leds_out.md
NIOS_LEDS_OUT -- requirements
Module: nios_leds_out

Interface
REQ-001 Parameter WIDTH, default 8, number of output bits driven on out_port.
REQ-002 Parameter RESET_VALUE, default 0, value loaded into the DATA register on reset.
REQ-003 Parameter BLINK_DIV_W, default 24, width of the blink prescaler counter.
REQ-004 Port clk, input, 1 bit, single clock for all logic.
REQ-005 Port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 Port address, input, 2 bits, Avalon-MM slave word address.
REQ-007 Port chipselect, input, 1 bit, slave select qualifier.
REQ-008 Port write_n, input, 1 bit, active-low write strobe.
REQ-009 Port writedata, input, 32 bits, write data.
REQ-010 Port readdata, output, 32 bits, registered read data.
REQ-011 Port out_port, output, WIDTH bits, LED drive.

Function
REQ-012 The block SHALL decode four registers: 0 = DATA (read/write), 1 = BLINK_MASK (read/write), 2 = SET (write-only), 3 = CLEAR (write-only).
- A write SHALL occur on a rising clk edge with chipselect=1 and write_n=0.
- Writes SHALL use writedata[WIDTH-1:0]; upper bits are ignored.
REQ-013 A DATA write SHALL load DATA on that edge.
REQ-014 A SET write SHALL perform DATA <= DATA | writedata[WIDTH-1:0].
REQ-015 A CLEAR write SHALL perform DATA <= DATA & ~writedata[WIDTH-1:0].
REQ-016 readdata SHALL be updated every clock, independent of chipselect, giving one-cycle read latency.
- address 0 returns zero-extended DATA.
- address 1 returns zero-extended BLINK_MASK.
- addresses 2 and 3 return 0.
REQ-017 out_port SHALL equal DATA ^ (BLINK_MASK & {WIDTH{phase}}), driven from registers with no combinational path from the bus inputs.
REQ-018 The prescaler SHALL increment every clock and wrap from all-ones to 0.
- phase SHALL toggle on the cycle the prescaler wraps.
- Blink period = 2^(BLINK_DIV_W+1) clocks.
REQ-019 A DATA/SET/CLEAR write coinciding with a phase toggle SHALL apply both; out_port SHALL reflect the new DATA with the new phase on the following cycle.
REQ-020 A BLINK_MASK write SHALL NOT reset the prescaler or phase.
REQ-021 Any write SHALL only affect its addressed register; a write with chipselect=0 SHALL have no effect.

Reset
REQ-022 Asserting reset SHALL asynchronously set:
- DATA = RESET_VALUE
- BLINK_MASK = 0
- prescaler = 0
- phase = 0
- readdata = 0
REQ-023 Reset asserted mid-blink SHALL immediately drive out_port = RESET_VALUE.
REQ-024 Counting SHALL restart from 0 on the first edge after reset deasserts.

Configuration
REQ-025 The macro NIOS_LEDS_BLINK_EN SHALL compile the blink feature in; this is the only configurable feature.
- Defined: BLINK_MASK, prescaler and phase exist, behaving per REQ-016..020.
- Undefined: no prescaler or phase logic; BLINK_MASK writes are ignored; address 1 reads 0; out_port = DATA.

Structure
REQ-026 Shared package nios_pio_pkg SHALL hold:
- register offset constants (ADDR_DATA, ADDR_BLINK_MASK, ADDR_SET, ADDR_CLEAR);
- the 32-bit bus data width constant.
REQ-027 The prescaler/phase logic SHALL be a sub-module nios_blink_prescaler (inputs clk, reset; output phase), instantiated only under NIOS_LEDS_BLINK_EN.

Verification
REQ-028 The bench SHALL cover these directed scenarios (WIDTH=8, BLINK_DIV_W=3, macro defined):
- Reset: assert reset -> out_port=0x00 and readdata=0 immediately; release -> still 0x00.
- DATA read-back: write 0xA5 to address 0, read address 0 -> out_port=0xA5 next cycle, readdata=0x000000A5 one cycle after address is presented.
- Set/clear: DATA=0x0F, SET 0xF0 -> 0xFF; CLEAR 0x3C -> 0xC3; writedata 0xFFFFFF00 to DATA -> 0x00.
- Blink: DATA=0x01, BLINK_MASK=0x80 -> out_port alternates 0x01 / 0x81 every 8 clocks; reading address 1 returns 0x80.
- Collision and mid-blink reset: SET 0x02 on the phase-toggle cycle -> both effects visible next cycle; reset mid-blink -> out_port=RESET_VALUE asynchronously and the blink period restarts.
- Macro undefined: BLINK_MASK write 0xFF -> address 1 reads 0 and out_port stays equal to DATA.
